// File: rtl/fp_consts.sv
// -----------------------------------------------------------------------------
// fp_consts
//   Shared constants, encodings and classification helpers for the FP unit's
//   IEEE-754 single-precision multiplier (and its divider counterpart).
//   Contents:
//     QNAN_SAMPLE_CONST        canonical quiet NaN returned for invalid ops
//     INFINITY_POSITIVE_CONST  +infinity; sign bit is spliced in by users
//     ZERO                     +0.0
//     EXP_BIAS                 single-precision exponent bias (127)
//     EXP_SPECIAL              exponent field marking NaN / infinity
//     fp_mul_state_t           multiplier FSM state encoding
//     is_nan / is_inf / is_zero  operand classification (exp==0 is zero,
//                                so denormals flush to zero)
// -----------------------------------------------------------------------------
package fp_consts;

    localparam logic [31:0] QNAN_SAMPLE_CONST       = 32'h7FC0_0000;
    localparam logic [31:0] INFINITY_POSITIVE_CONST = 32'h7F80_0000;
    localparam logic [31:0] ZERO                    = 32'h0000_0000;
    localparam int          EXP_BIAS                = 127;
    localparam logic [7:0]  EXP_SPECIAL             = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_NORM,
        ST_DONE
    } fp_mul_state_t;

    // NaN pattern: all-ones exponent with a non-zero fraction.
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == EXP_SPECIAL) && (x[22:0] != 23'd0);
    endfunction

    // Infinity pattern: all-ones exponent with a zero fraction.
    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == EXP_SPECIAL) && (x[22:0] == 23'd0);
    endfunction

    // Any zero exponent counts as zero; denormals are flushed.
    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:23] == 8'd0);
    endfunction

endpackage

// File: rtl/fp_mul_normalize_round.sv
// -----------------------------------------------------------------------------
// fp_mul_normalize_round
//   Combinational back end of the sequential FP multiplier. Normalises the
//   48-bit mantissa product, optionally rounds, and range-checks the exponent.
//   Ports:
//     product   in  48  raw {1,fa} * {1,fb} mantissa product
//     exp_in    in  10  signed biased exponent ea + eb - 127
//     sign      in  1   result sign
//     result    out 32  packed single-precision result
//     overflow  out 1   exponent >= 255; result is signed infinity
//     underflow out 1   exponent <= 0; result is signed zero
//   Build option:
//     FP_MUL_ROUND_NEAREST_EN  defined   -> round-to-nearest-even
//                              undefined -> truncation
// -----------------------------------------------------------------------------
module fp_mul_normalize_round
    import fp_consts::*;
(
    input  logic [47:0]        product,
    input  logic signed [9:0]  exp_in,
    input  logic               sign,
    output logic [31:0]        result,
    output logic               overflow,
    output logic               underflow
);

    logic signed [9:0] exp_n;
    logic [22:0]       frac;
`ifdef FP_MUL_ROUND_NEAREST_EN
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [23:0]       frac_rnd;
`else
    // Bits below the kept fraction are discarded by truncation.
    logic              unused_low_bits;
    assign unused_low_bits = |product[22:0];
`endif

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no
        // path through this block can leave one unassigned (no latches).
        exp_n = exp_in;
        frac  = product[45:23];
`ifdef FP_MUL_ROUND_NEAREST_EN
        guard    = product[22];
        sticky   = |product[21:0];
        round_up = 1'b0;
        frac_rnd = 24'd0;
`endif

        // Product of two [1,2) mantissas lies in [1,4); a set bit 47 means
        // the value is >= 2 and the binary point moves one place left.
        if (product[47]) begin
            exp_n = exp_in + 10'sd1;
            frac  = product[46:24];
`ifdef FP_MUL_ROUND_NEAREST_EN
            guard  = product[23];
            sticky = |product[22:0];
`endif
        end

`ifdef FP_MUL_ROUND_NEAREST_EN
        round_up = guard & (sticky | frac[0]);
        frac_rnd = {1'b0, frac} + {23'd0, round_up};
        // Fraction carry-out: 1.111..1 + ulp = 10.0, bump the exponent.
        if (frac_rnd[23]) begin
            exp_n = exp_n + 10'sd1;
        end
        frac = frac_rnd[22:0];
`endif

        overflow  = (exp_n >= 10'sd255);
        underflow = (exp_n <= 10'sd0);

        if (overflow) begin
            result = {sign, INFINITY_POSITIVE_CONST[30:0]};
        end else if (underflow) begin
            result = {sign, ZERO[30:0]};
        end else begin
            result = {sign, exp_n[7:0], frac};
        end
    end

endmodule

// File: rtl/fp_multiplier_seq.sv
// -----------------------------------------------------------------------------
// fp_multiplier_seq
//   Multi-cycle IEEE-754 single-precision multiplier, result = a * b, built on
//   an iterative shift-add mantissa multiplier with a start/busy/done
//   handshake. Flags share the divider's semantics.
//   Parameters:
//     RADIX_BITS  multiplier bits consumed per MUL cycle: 1,2,3,4,6 or 8
//   Ports:
//     clk       in  1   rising-edge clock
//     rst_b     in  1   synchronous active-low reset
//     start     in  1   request pulse, sampled only in IDLE
//     a         in  32  multiplicand
//     b         in  32  multiplier
//     busy      out 1   high from the cycle after start through the done cycle
//     done      out 1   one-cycle pulse; result and flags valid from here
//     result    out 32  product
//     overflow  out 1   exponent overflow (signed infinity)
//     underflow out 1   exponent underflow (signed zero)
//   Build option:
//     FP_MUL_ROUND_NEAREST_EN selects round-to-nearest-even in the normaliser;
//     latency is the same in both builds.
// -----------------------------------------------------------------------------
module fp_multiplier_seq
    import fp_consts::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    localparam int ITERS = 24 / RADIX_BITS;
    localparam int CNT_W = 5;

    if (RADIX_BITS != 1 && RADIX_BITS != 2 && RADIX_BITS != 3 &&
        RADIX_BITS != 4 && RADIX_BITS != 6 && RADIX_BITS != 8) begin : g_bad_radix
        $error("fp_multiplier_seq: RADIX_BITS must be one of 1,2,3,4,6,8");
    end

    fp_mul_state_t      state_q;
    fp_mul_state_t      state_d;
    logic               busy_d;
    logic               done_d;

    logic               sign_q;
    logic [7:0]         ea_q;
    logic [7:0]         eb_q;
    logic [47:0]        mcand_q;
    logic [23:0]        mplier_q;
    logic [47:0]        acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               op_sign;
    logic               special_hit;
    logic [31:0]        special_result;
    logic [47:0]        partial;
    logic signed [9:0]  exp_sum;
    logic [31:0]        nr_result;
    logic               nr_overflow;
    logic               nr_underflow;

    // ---------------------------------------------------------------------
    // Operand classification on the live inputs (used only in the start cycle)
    // ---------------------------------------------------------------------
    assign op_sign = a[31] ^ b[31];

    always_comb begin
        special_hit    = is_nan(a) || is_nan(b) || is_inf(a) || is_inf(b) ||
                         is_zero(a) || is_zero(b);
        special_result = {op_sign, ZERO[30:0]};
        if (is_nan(a) || is_nan(b)) begin
            special_result = QNAN_SAMPLE_CONST;
        end else if ((is_zero(a) && is_inf(b)) || (is_inf(a) && is_zero(b))) begin
            special_result = QNAN_SAMPLE_CONST;
        end else if (is_inf(a) || is_inf(b)) begin
            special_result = {op_sign, INFINITY_POSITIVE_CONST[30:0]};
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // busy/done are registered so the done pulse lands one cycle after the
    // DONE state, with busy covering that cycle.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_b) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = special_hit ? ST_DONE : ST_MUL;
            ST_MUL:  if (cnt_q == CNT_W'(ITERS - 1)) state_d = ST_NORM;
            ST_NORM: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: output logic
    always_comb begin
        busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
        done_d = (state_q == ST_DONE);
    end

    // ---------------------------------------------------------------------
    // Shift-add partial product: RADIX_BITS multiplier LSBs per cycle
    // ---------------------------------------------------------------------
    always_comb begin
        partial = 48'd0;
        for (int j = 0; j < RADIX_BITS; j++) begin
            if (mplier_q[j]) begin
                partial = partial + (mcand_q << j);
            end
        end
    end

    assign exp_sum = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'(EXP_BIAS);

    // ---------------------------------------------------------------------
    // Operand registers
    // NOTE: these are always loaded on an accepted start before being read,
    // so they carry no reset; only control, accumulator and outputs do.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && start) begin
            sign_q   <= op_sign;
            ea_q     <= a[30:23];
            eb_q     <= b[30:23];
            mcand_q  <= {24'd0, 1'b1, a[22:0]};
            mplier_q <= {1'b1, b[22:0]};
        end else if (state_q == ST_MUL) begin
            mcand_q  <= mcand_q << RADIX_BITS;
            mplier_q <= mplier_q >> RADIX_BITS;
        end
    end

    // Accumulator, iteration counter and architectural outputs
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            acc_q     <= 48'd0;
            cnt_q     <= '0;
            result    <= ZERO;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q     <= 48'd0;
                        cnt_q     <= '0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        if (special_hit) begin
                            result <= special_result;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q <= acc_q + partial;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_NORM: begin
                    result    <= nr_result;
                    overflow  <= nr_overflow;
                    underflow <= nr_underflow;
                end
                default: ;
            endcase
        end
    end

    fp_mul_normalize_round u_norm (
        .product   (acc_q),
        .exp_in    (exp_sum),
        .sign      (sign_q),
        .result    (nr_result),
        .overflow  (nr_overflow),
        .underflow (nr_underflow)
    );

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_multiplier_seq
//   Drives two multipliers (RADIX_BITS=1 and RADIX_BITS=4) from shared inputs
//   and checks results, flags and latency against an integer reference model.
// -----------------------------------------------------------------------------
module tb_fp_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;

    logic        busy1, done1, ovf1, unf1;
    logic [31:0] res1;
    logic        busy4, done4, ovf4, unf4;
    logic [31:0] res4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_multiplier_seq #(.RADIX_BITS(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .start(start), .a(a), .b(b),
        .busy(busy1), .done(done1), .result(res1),
        .overflow(ovf1), .underflow(unf1)
    );

    fp_multiplier_seq #(.RADIX_BITS(4)) dut4 (
        .clk(clk), .rst_b(rst_b), .start(start), .a(a), .b(b),
        .busy(busy4), .done(done4), .result(res4),
        .overflow(ovf4), .underflow(unf4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: returns {overflow, underflow, result}.
    function automatic logic [33:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          ex, ey, e, sh;
        logic [63:0] mx, my, p, frac, rem, half;
        logic        nx, ny, ix, iy, zx, zy;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = {41'd0, x[22:0]};
        my = {41'd0, y[22:0]};
        nx = (ex == 255) && (mx != 0);
        ny = (ey == 255) && (my != 0);
        ix = (ex == 255) && (mx == 0);
        iy = (ey == 255) && (my == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        if (nx || ny) return {2'b00, 32'h7FC0_0000};
        if ((zx && iy) || (ix && zy)) return {2'b00, 32'h7FC0_0000};
        if (ix || iy) return {2'b00, s, 31'h7F80_0000};
        if (zx || zy) return {2'b00, s, 31'h0};
        p    = (mx | (64'd1 << 23)) * (my | (64'd1 << 23));
        sh   = (p >= (64'd1 << 47)) ? 24 : 23;
        e    = ex + ey - 127 + ((sh == 24) ? 1 : 0);
        frac = (p >> sh) & 64'h7F_FFFF;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
`ifdef FP_MUL_ROUND_NEAREST_EN
        if (rem > half || (rem == half && frac[0])) frac = frac + 64'd1;
        if (frac == 64'h80_0000) begin
            frac = 64'd0;
            e    = e + 1;
        end
`else
        if (rem > half) frac = frac;
`endif
        if (e >= 255) return {2'b10, s, 31'h7F80_0000};
        if (e <= 0)   return {2'b01, s, 31'h0};
        return {2'b00, s, e[7:0], frac[22:0]};
    endfunction

    function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'd0) || (x[30:23] == 8'hFF) ||
               (y[30:23] == 8'd0) || (y[30:23] == 8'hFF);
    endfunction

    // One operation through both DUTs with full result/flag/latency checks.
    task automatic do_op(input string name, input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic [31:0] exp_res, input logic exp_ovf, input logic exp_unf);
        int          lat1, lat4, exp_l1, exp_l4;
        logic [31:0] r1, r4;
        logic        o1, u1, o4, u4, bz1;
        bit          sp;
        sp     = is_special(op_a, op_b);
        exp_l1 = sp ? 1 : 26;
        exp_l4 = sp ? 1 : 8;
        lat1 = 0; lat4 = 0;
        r1 = '0; r4 = '0; o1 = 0; u1 = 0; o4 = 0; u4 = 0; bz1 = 0;
        @(negedge clk);
        a = op_a; b = op_b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        check({name, "/flags_clear"}, {30'd0, ovf1, unf1}, 32'd0);
        for (int c = 1; c <= 60 && (lat1 == 0 || lat4 == 0); c++) begin
            @(posedge clk);
            #1;
            if (done1 && lat1 == 0) begin
                lat1 = c; r1 = res1; o1 = ovf1; u1 = unf1; bz1 = busy1;
            end
            if (done4 && lat4 == 0) begin
                lat4 = c; r4 = res4; o4 = ovf4; u4 = unf4;
            end
        end
        check({name, "/lat_r1"}, 32'(lat1), 32'(exp_l1));
        check({name, "/lat_r4"}, 32'(lat4), 32'(exp_l4));
        check({name, "/res_r1"}, r1, exp_res);
        check({name, "/res_r4"}, r4, exp_res);
        check({name, "/flags_r1"}, {30'd0, o1, u1}, {30'd0, exp_ovf, exp_unf});
        check({name, "/flags_r4"}, {30'd0, o4, u4}, {30'd0, exp_ovf, exp_unf});
        check({name, "/busy_at_done"}, {31'd0, bz1}, 32'd1);
    endtask

    initial begin
        logic [33:0] m;
        logic [31:0] ra, rb, r;
        int          dones;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset/result", res1, 32'd0);
        check("reset/ctrl", {28'd0, busy1, done1, ovf1, unf1}, 32'd0);
        check("reset/ctrl_r4", {28'd0, busy4, done4, ovf4, unf4}, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;

        // Directed cases
        do_op("mul_1p5x2",   32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
        do_op("mul_m3x3",    32'hC040_0000, 32'h4040_0000, 32'hC110_0000, 1'b0, 1'b0);
        do_op("zero_x_inf",  32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b0);
        do_op("inf_x_m1",    32'h7F80_0000, 32'hBF80_0000, 32'hFF80_0000, 1'b0, 1'b0);
        do_op("nan_x_1",     32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0);
        do_op("m0_x_2",      32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0);
        do_op("overflow",    32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0);
        do_op("underflow",   32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1);
        do_op("flag_clear",  32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
`ifdef FP_MUL_ROUND_NEAREST_EN
        do_op("round_case",  32'h3F80_0005, 32'h3FC0_0000, 32'h3FC0_0008, 1'b0, 1'b0);
`else
        do_op("round_case",  32'h3F80_0005, 32'h3FC0_0000, 32'h3FC0_0007, 1'b0, 1'b0);
`endif

        // Randomised cases against the reference model
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 != 3) begin
                ra[30:23] = 8'($urandom_range(60, 190));
                rb[30:23] = 8'($urandom_range(60, 190));
            end
            m = ref_mul(ra, rb);
            do_op($sformatf("rand%0d", i), ra, rb, m[31:0], m[33], m[32]);
        end

        // start re-pulsed at cycles 3 and 10 of a running op
        dones = 0;
        r = '0;
        @(negedge clk);
        a = 32'h3FC0_0000; b = 32'h4000_0000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 3 || c == 10) begin
                start = 1'b1; a = $urandom; b = $urandom;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done1) begin
                dones++;
                r = res1;
            end
        end
        check("ignore_start/done_count", 32'(dones), 32'd1);
        check("ignore_start/result", r, 32'h4040_0000);

        // Reset at cycle 5 of MUL aborts silently
        @(negedge clk);
        a = 32'hC040_0000; b = 32'h4040_0000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        check("abort/result", res1, 32'd0);
        check("abort/ctrl", {28'd0, busy1, done1, ovf1, unf1}, 32'd0);
        check("abort/ctrl_r4", {28'd0, busy4, done4, ovf4, unf4}, 32'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done1 || done4) dones++;
        end
        check("abort/no_done", 32'(dones), 32'd0);
        do_op("after_abort", 32'hC040_0000, 32'h4040_0000, 32'hC110_0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
